// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath constants: float layout, fixed-point defaults and the
// fixed->float conversion state encoding.
package cordic_pkg;

    localparam int FLOAT_DATA_WIDTH = 32;
    localparam int FP_EXP_BIAS      = 127;
    localparam int FP_EXP_WIDTH     = 8;
    localparam int FP_MANT_WIDTH    = 23;

    // Default Qm.n format of the CORDIC datapath (m includes the sign bit).
    localparam int CORDIC_INTEGER_WIDTH    = 4;
    localparam int CORDIC_FRACTIONAL_WIDTH = 20;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_NORM_ENC = 2'd1;
    localparam logic [1:0] ST_PACK_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        NORM = ST_NORM_ENC,
        PACK = ST_PACK_ENC
    } f2f_state_t;

endpackage

// File: rtl/fx_normalise.sv
// Registered normaliser: shifts a magnitude left one bit per enabled cycle until
// its MSB is set, counting the shifts taken.
module fx_normalise #(
    parameter int W     = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic             en,
    output logic [W-1:0]     mag,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             ready
);

    assign ready = mag[W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            mag       <= '0;
            shift_cnt <= '0;
        end else if (load) begin
            mag       <= load_val;
            shift_cnt <= '0;
        end else if (en && !mag[W-1]) begin
            mag       <= mag << 1;
            shift_cnt <= shift_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fixed_to_float.sv
// Signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH) to IEEE-754 single converter with a
// start/busy/done handshake; exact because the operand never exceeds 24 bits.
module fixed_to_float
    import cordic_pkg::*;
#(
    parameter int INTEGER_WIDTH    = cordic_pkg::CORDIC_INTEGER_WIDTH,
    parameter int FRACTIONAL_WIDTH = cordic_pkg::CORDIC_FRACTIONAL_WIDTH,
    parameter int FLOAT_DATA_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH,
    localparam int W               = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [W-1:0]                fixed_in,
    output logic                        busy,
    output logic                        done,
    output logic [FLOAT_DATA_WIDTH-1:0] result,
    output logic [1:0]                  state_dbg
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    // Handshake: start is sampled only on edges where busy=0 (IDLE, including the
    // done cycle); done is a one-cycle registered pulse and result holds afterwards.
    f2f_state_t state;

    logic                     accept;
    logic [W-1:0]             abs_in;
    logic                     sign_q;
    logic [W-1:0]             mag;
    logic [CNT_W-1:0]         shift_cnt;
    logic                     norm_ready;
    logic [FP_EXP_WIDTH-1:0]  exp_field;
    logic [FP_MANT_WIDTH-1:0] mant_field;

    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Two's-complement negate as W-bit unsigned: the most negative input maps to 2^(W-1).
    assign abs_in = fixed_in[W-1] ? (~fixed_in + W'(1)) : fixed_in;

    fx_normalise #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_norm (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_val  (abs_in),
        .en        (state == NORM),
        .mag       (mag),
        .shift_cnt (shift_cnt),
        .ready     (norm_ready)
    );

    // Leading one is implicit; the remaining bits are left-aligned into the 23-bit field.
    assign exp_field  = FP_EXP_WIDTH'(FP_EXP_BIAS + INTEGER_WIDTH - 1 - int'(shift_cnt));
    assign mant_field = FP_MANT_WIDTH'(mag[W-2:0]) << (FP_MANT_WIDTH + 1 - W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            sign_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= fixed_in[W-1];
                        if (fixed_in == '0) begin
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (norm_ready) begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    result <= FLOAT_DATA_WIDTH'({sign_q, exp_field, mant_field});
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float.sv
// Bench for fixed_to_float at the default Q4.20 format: directed vectors, handshake
// and reset cases, and a random sweep checked against an arithmetic float model.
module tb_fixed_to_float;

    localparam int IW = 4;
    localparam int FW = 20;
    localparam int W  = IW + FW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  fixed_in;
    logic          busy;
    logic          done;
    logic [31:0]   result;
    logic [1:0]    state_dbg;

    int tests_run;
    int tests_failed;
    int cyc;
    bit chk_on;

    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] held_exp;

    fixed_to_float #(
        .INTEGER_WIDTH    (IW),
        .FRACTIONAL_WIDTH (FW),
        .FLOAT_DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fixed_in  (fixed_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        tests_run++;
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // ---------------- reference model ----------------
    function automatic int top_bit(input int m);
        int p;
        p = 0;
        for (int i = 0; i < 31; i++) begin
            if (m >= (1 << i)) p = i;
        end
        return p;
    endfunction

    function automatic int magnitude(input logic [W-1:0] x);
        return x[W-1] ? ((1 << W) - int'(x)) : int'(x);
    endfunction

    // value = m * 2^-FW with leading one at bit p  ->  exponent p - FW
    function automatic logic [31:0] model_float(input logic [W-1:0] x);
        int m, p;
        if (x == '0) return 32'h0;
        m = magnitude(x);
        p = top_bit(m);
        return {x[W-1], 8'(127 + p - FW), 23'((m << (23 - p)) & 32'h7F_FFFF)};
    endfunction

    // edges after the accepting edge until done is seen; zero completes on that edge
    function automatic int model_lat(input logic [W-1:0] x);
        if (x == '0) return 0;
        return (W - 1 - top_bit(magnitude(x))) + 2;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: each accepted conversion is due on a known cycle
    always @(negedge clk) begin
        logic exp_done, exp_busy;
        if (chk_on) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
            if (exp_q.size() > 0) begin
                if (cyc == due_q[0]) begin
                    exp_done = 1'b1;
                    held_exp = exp_q.pop_front();
                    void'(due_q.pop_front());
                end else begin
                    exp_busy = (cyc < due_q[0]);
                end
            end
            check("done", 32'(done), 32'(exp_done));
            check("busy", 32'(busy), 32'(exp_busy));
            check("result", result, held_exp);
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic start_conv(input logic [W-1:0] x, input logic [31:0] res, input int lat);
        int acc;
        start    = 1'b1;
        fixed_in = x;
        acc      = cyc + 1;
        @(posedge clk); #1;
        start    = 1'b0;
        fixed_in = W'($urandom);
        exp_q.push_back(res);
        due_q.push_back(acc + lat);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            check("wait_idle_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 60; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        if (i == 60) check("wait_done_timeout", 32'(done), 32'h1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        due_q.delete();
        held_exp = 32'h0;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] vec_x   [8] = '{24'h100000, 24'hF00000, 24'h080000, 24'h800000,
                                  24'h7FFFFF, 24'h000001, 24'h000000, 24'hFFFFFF};
    logic [31:0]  vec_res [8] = '{32'h3F800000, 32'hBF800000, 32'h3F000000, 32'hC1000000,
                                  32'h40FFFFFE, 32'h35800000, 32'h00000000, 32'hB5800000};
    int           vec_lat [8] = '{5, 5, 6, 2, 3, 25, 0, 25};

    initial begin
        logic [W-1:0] x;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        chk_on       = 1'b0;
        held_exp     = 32'h0;
        rst          = 1'b1;
        start        = 1'b0;
        fixed_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // directed vectors, also pinning the model against hand-computed values
        foreach (vec_x[i]) begin
            check("model_result", model_float(vec_x[i]), vec_res[i]);
            check("model_latency", 32'(model_lat(vec_x[i])), 32'(vec_lat[i]));
            wait_idle();
            start_conv(vec_x[i], vec_res[i], vec_lat[i]);
        end
        wait_idle();

        // start held with a new operand while busy must be ignored
        start_conv(24'h100000, 32'h3F800000, 5);
        start    = 1'b1;
        fixed_in = 24'h080000;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();

        // start in the done cycle is accepted immediately
        start_conv(24'h080000, 32'h3F000000, 6);
        wait_done();
        start_conv(24'h800000, 32'hC1000000, 2);
        wait_done();
        start_conv(24'h000000, 32'h00000000, 0);
        wait_done();
        start_conv(24'hF00000, 32'hBF800000, 5);
        wait_idle();

        // reset in the middle of normalisation aborts without a done pulse
        start_conv(24'h000001, 32'h35800000, 25);
        repeat (5) begin
            @(posedge clk); #1;
        end
        pulse_reset();
        repeat (30) begin
            @(posedge clk); #1;
        end
        start_conv(24'h7FFFFF, 32'h40FFFFFE, 3);
        wait_idle();

        // random sweep against the model, mixing idle gaps and back-to-back starts
        for (int n = 0; n < 60; n++) begin
            x = W'($urandom_range(0, 32'hFF_FFFF));
            x = x >> $urandom_range(0, 23);
            if ($urandom_range(0, 1) == 1) x = ~x + W'(1);
            start_conv(x, model_float(x), model_lat(x));
            if ($urandom_range(0, 1) == 1) wait_done();
            else wait_idle();
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
